// File: rtl/lane_deskew_ctrl_pkg.sv
// Shared PCIe MAC definitions for the lane deskew controller: FSM encoding,
// alignment marker, lane-count legality and the per-lane FIFO entry layout.
package lane_deskew_ctrl_pkg;
    localparam int NUM_LANES = 16;
    localparam int LANE_W    = 32;
    localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
    localparam logic [5:0] PIPEWIDTH_OK = 6'd32;
    localparam logic [4:0] LEGAL_LANES [5] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MARK = 2'd1,
        ALIGNED   = 2'd2,
        ERROR     = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]        k;
        logic [LANE_W-1:0] d;
    } lane_word_t;

    function automatic logic lanes_legal(input logic [4:0] n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 5; i++)
            if (n == LEGAL_LANES[i]) ok = 1'b1;
        return ok;
    endfunction

    function automatic logic is_marker(input lane_word_t w, input logic [7:0] com);
        return w.k[0] && (w.d[7:0] == com);
    endfunction
endpackage

// File: rtl/lane_deskew_ctrl_if.sv
// Lane word bus into the deskew controller and the aligned bus out of it.
interface lane_deskew_ctrl_if;
    import lane_deskew_ctrl_pkg::*;
    logic [NUM_LANES*LANE_W-1:0] laneData;
    logic [NUM_LANES*4-1:0]      laneDataK;
    logic                        laneValid;
    logic [NUM_LANES*LANE_W-1:0] alignedData;
    logic [NUM_LANES*4-1:0]      alignedDataK;
    logic                        alignedValid;

    modport master (output laneData, laneDataK, laneValid,
                    input  alignedData, alignedDataK, alignedValid);
    modport slave  (input  laneData, laneDataK, laneValid,
                    output alignedData, alignedDataK, alignedValid);
endinterface

// File: rtl/lane_deskew_fifo.sv
// One-lane deskew FIFO: DEPTH entries of data+K, push/pop in the same cycle
// is allowed even when full, flush empties it in one clock.
module lane_deskew_fifo
    import lane_deskew_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  lane_word_t wdata,
    output lane_word_t rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    lane_word_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only consumed while occupied.
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/lane_deskew_ctrl.sv
// Multi-lane deskew: buffers each lane from its alignment marker onward, then
// releases all active lanes together once the latest lane's marker arrives.
module lane_deskew_ctrl
    import lane_deskew_ctrl_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] COM_SYM = COM_SYM_DEF
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [5:0]               PIPEWIDTH,
    input  logic [4:0]               LANESNUMBER,
    lane_deskew_ctrl_if.slave        bus,
    output logic                     deskewDone,
    output logic                     deskewError
);
    localparam int SW = $clog2(DEPTH + 1);

    state_t                      state;
    logic [4:0]                  lanes_q;
    logic [SW-1:0]               skew;
    logic [NUM_LANES-1:0]        active, seen, mark, pmark, push, pop;
    lane_word_t [NUM_LANES-1:0]  win, head;
    logic [NUM_LANES*LANE_W-1:0] hd_d, a_d;
    logic [NUM_LANES*4-1:0]      hd_k, a_k;
    logic                        a_v, flush, any_seen, skew_out, all_marked, set_bad;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign win[n]    = {bus.laneDataK[4*n +: 4], bus.laneData[LANE_W*n +: LANE_W]};
        assign active[n] = (5'(n) < lanes_q);
        assign mark[n]   = bus.laneValid && is_marker(win[n], COM_SYM);
        assign pmark[n]  = active[n] && is_marker(head[n], COM_SYM);
        assign hd_d[LANE_W*n +: LANE_W] = active[n] ? head[n].d : '0;
        assign hd_k[4*n +: 4]           = active[n] ? head[n].k : '0;

        lane_deskew_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push[n]),
            .pop   (pop[n]),
            .wdata (win[n]),
            .rdata (head[n])
        );
    end

    assign flush      = !enable || (state == IDLE);
    assign any_seen   = |(seen & active);
    // Counter would hit DEPTH this cycle: the earliest lanes' FIFOs are full,
    // so a lane still unmarked cannot be aligned any more.
    assign skew_out   = bus.laneValid && any_seen && (skew == SW'(DEPTH - 1));
    assign all_marked = (((seen | mark) & active) == active);
    assign set_bad    = (|pmark) && (pmark != active);

    always_comb begin
        push = '0;
        pop  = '0;
        case (state)
            WAIT_MARK: push = {NUM_LANES{bus.laneValid && !skew_out}} & active & (seen | mark);
            ALIGNED: begin
                push = {NUM_LANES{bus.laneValid}} & active;
                pop  = {NUM_LANES{bus.laneValid}} & active;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE; lanes_q <= '0; seen <= '0; skew <= '0;
            a_d <= '0; a_k <= '0; a_v <= 1'b0; deskewDone <= 1'b0; deskewError <= 1'b0;
        end else if (!enable) begin
            state <= IDLE; seen <= '0; skew <= '0;
            a_d <= '0; a_k <= '0; a_v <= 1'b0; deskewDone <= 1'b0; deskewError <= 1'b0;
        end else begin
            a_v <= 1'b0;
            case (state)
                IDLE: if (PIPEWIDTH == PIPEWIDTH_OK && lanes_legal(LANESNUMBER)) begin
                    state   <= WAIT_MARK;
                    lanes_q <= LANESNUMBER;
                end
                WAIT_MARK: if (bus.laneValid) begin
                    if (skew_out) begin
                        state       <= ERROR;
                        deskewError <= 1'b1;
                    end else begin
                        seen <= seen | (mark & active);
                        if (any_seen) skew <= skew + 1'b1;
                        if (all_marked) begin
                            state      <= ALIGNED;
                            deskewDone <= 1'b1;
                        end
                    end
                end
                ALIGNED: if (bus.laneValid) begin
                    if (set_bad) begin
                        state       <= ERROR;
                        deskewDone  <= 1'b0;
                        deskewError <= 1'b1;
                    end else begin
                        a_v <= 1'b1;
                        a_d <= hd_d;
                        a_k <= hd_k;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alignedData  = a_d;
    assign bus.alignedDataK = a_k;
    assign bus.alignedValid = a_v;
endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Table-driven bench for lane_deskew_ctrl with an output scoreboard, plus
// hand sequences for latency, partial-marker error and mid-run reset.
module tb_lane_deskew_ctrl;
    import lane_deskew_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic [5:0] PIPEWIDTH = 6'd32;
    logic [4:0] LANESNUMBER = 5'd1;
    logic deskewDone, deskewError;
    int checks = 0, errors = 0, n_out = 0;

    lane_deskew_ctrl_if bus();

    lane_deskew_ctrl #(.DEPTH(4), .COM_SYM(8'hBC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .PIPEWIDTH(PIPEWIDTH),
        .LANESNUMBER(LANESNUMBER), .bus(bus),
        .deskewDone(deskewDone), .deskewError(deskewError)
    );

    always #5 clk = ~clk;

    typedef struct { logic [511:0] d; logic [63:0] k; } set_t;
    typedef struct {
        int lanes; int pw; int late_lane; int late_by; int ncyc;
        bit gaps; bit exp_done; bit exp_err; int exp_outs;
    } vec_t;

    set_t sb[$];
    vec_t vt[8];

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        set_t e;
        @(posedge clk);
        @(negedge clk);
        if (bus.alignedValid === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out act=%0h exp=none", bus.alignedData);
            end else begin
                e = sb.pop_front();
                chk("aligned_set", {bus.alignedDataK, bus.alignedData}, {e.k, e.d});
            end
        end
    endtask

    // Lane word: marker at index mt, otherwise K-free data whose byte 0 is never COM.
    function automatic logic [35:0] lw(input int n, input int idx, input int mt);
        if (idx == mt) return {4'b0001, 8'(n), 8'(idx), 8'hA5, 8'hBC};
        return {4'b0000, 8'(n), 8'(idx), 8'(n * 7 + idx * 13 + 1), 8'h5A};
    endfunction

    function automatic int mt_of(input int n, input int late_lane, input int late_by);
        return (n == late_lane) ? late_by : 0;
    endfunction

    task automatic drive_set(input int lanes, input int t, input int ll, input int lb, input bit v);
        logic [35:0] w;
        logic [63:0] r;
        for (int n = 0; n < NUM_LANES; n++) begin
            r = {$urandom(), $urandom()};
            w = (v && n < lanes) ? lw(n, t, mt_of(n, ll, lb)) : r[35:0];
            bus.laneData[32*n +: 32] = w[31:0];
            bus.laneDataK[4*n +: 4]  = w[35:32];
        end
        bus.laneValid = v;
    endtask

    function automatic set_t exp_set(input int lanes, input int j, input int ll, input int lb);
        set_t s;
        logic [35:0] w;
        s.d = '0; s.k = '0;
        for (int n = 0; n < lanes; n++) begin
            w = lw(n, mt_of(n, ll, lb) + j, mt_of(n, ll, lb));
            s.d[32*n +: 32] = w[31:0];
            s.k[4*n +: 4]   = w[35:32];
        end
        return s;
    endfunction

    task automatic disable_and_check(input string tag);
        enable = 1'b0;
        bus.laneValid = 1'b0;
        step();
        sb.delete();
        chk({tag, "_off_status"}, {deskewDone, deskewError, bus.alignedValid}, 3'b000);
        chk({tag, "_off_data"}, {bus.alignedDataK, bus.alignedData}, '0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int t, cyc, T, n0;
        T = (v.late_lane >= 0) ? v.late_by : 0;
        enable = 1'b1; PIPEWIDTH = 6'(v.pw); LANESNUMBER = 5'(v.lanes);
        bus.laneValid = 1'b0;
        step();
        // Config is latched on leaving IDLE; these must be ignored.
        PIPEWIDTH = 6'd16; LANESNUMBER = 5'd3;
        n0 = n_out; t = 0; cyc = 0;
        while (t < v.ncyc) begin
            if (v.gaps && (cyc % 3 == 2)) drive_set(v.lanes, t, v.late_lane, v.late_by, 1'b0);
            else begin
                drive_set(v.lanes, t, v.late_lane, v.late_by, 1'b1);
                if (v.exp_done && t >= T) sb.push_back(exp_set(v.lanes, t - T, v.late_lane, v.late_by));
                t++;
            end
            cyc++;
            step();
        end
        bus.laneValid = 1'b0;
        chk({tag, "_done"}, 576'(deskewDone), 576'(v.exp_done));
        chk({tag, "_err"}, 576'(deskewError), 576'(v.exp_err));
        chk({tag, "_outs"}, 576'(n_out - n0), 576'(v.exp_outs));
        if (!v.exp_done) chk({tag, "_quiet_data"}, {bus.alignedDataK, bus.alignedData}, '0);
        disable_and_check(tag);
    endtask

    initial begin
        vt[0] = '{16, 32, -1,  0, 6, 1'b0, 1'b1, 1'b0, 5};
        vt[1] = '{ 4, 32,  2,  3, 8, 1'b0, 1'b1, 1'b0, 4};
        vt[2] = '{ 8, 32,  7, 99, 6, 1'b0, 1'b0, 1'b1, 0};
        vt[3] = '{ 1, 32, -1,  0, 4, 1'b0, 1'b1, 1'b0, 3};
        vt[4] = '{ 2, 32,  1,  3, 7, 1'b1, 1'b1, 1'b0, 3};
        vt[5] = '{ 2, 32,  1,  4, 7, 1'b0, 1'b0, 1'b1, 0};
        vt[6] = '{ 3, 32, -1,  0, 5, 1'b0, 1'b0, 1'b0, 0};
        vt[7] = '{16, 16, -1,  0, 5, 1'b0, 1'b0, 1'b0, 0};

        bus.laneData = '0; bus.laneDataK = '0; bus.laneValid = 1'b0;
        #12;
        chk("reset_status", {deskewDone, deskewError, bus.alignedValid}, 3'b000);
        chk("reset_data", {bus.alignedDataK, bus.alignedData}, '0);
        @(negedge clk); reset = 1'b1;
        step();
        chk("post_reset_status", {deskewDone, deskewError, bus.alignedValid}, 3'b000);

        for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Zero-skew latency: ALIGNED one clock after markers, data one valid cycle later.
        enable = 1'b1; PIPEWIDTH = 6'd32; LANESNUMBER = 5'd16; bus.laneValid = 1'b0;
        step();
        drive_set(16, 0, -1, 0, 1'b1); sb.push_back(exp_set(16, 0, -1, 0));
        step();
        chk("lat_done", {deskewDone, bus.alignedValid}, 2'b10);
        drive_set(16, 1, -1, 0, 1'b1); sb.push_back(exp_set(16, 1, -1, 0));
        step();
        chk("lat_valid", 576'(bus.alignedValid), 576'(1));
        disable_and_check("lat");

        // Partial marker in ALIGNED with 2 lanes.
        enable = 1'b1; LANESNUMBER = 5'd2;
        step();
        drive_set(2, 0, -1, 0, 1'b1); sb.push_back(exp_set(2, 0, -1, 0));
        step();
        drive_set(2, 1, -1, 0, 1'b1); sb.push_back(exp_set(2, 1, -1, 0));
        step();
        drive_set(2, 2, -1, 0, 1'b1);
        bus.laneData[7:0] = 8'hBC; bus.laneDataK[0] = 1'b1;
        step();
        chk("part_prev_valid", 576'(bus.alignedValid), 576'(1));
        drive_set(2, 3, -1, 0, 1'b1);
        step();
        chk("part_status", {deskewDone, deskewError, bus.alignedValid}, 3'b010);
        drive_set(2, 4, -1, 0, 1'b1);
        step();
        chk("part_sticky", {deskewDone, deskewError, bus.alignedValid}, 3'b010);
        chk("part_sb_drained", 576'(sb.size()), 576'(0));
        disable_and_check("part");

        // Reset in the middle of ALIGNED, then a full skewed re-deskew.
        enable = 1'b1; PIPEWIDTH = 6'd32; LANESNUMBER = 5'd4;
        step();
        drive_set(4, 0, -1, 0, 1'b1); sb.push_back(exp_set(4, 0, -1, 0));
        step();
        drive_set(4, 1, -1, 0, 1'b1); sb.push_back(exp_set(4, 1, -1, 0));
        step();
        chk("rst_mid_valid", 576'(bus.alignedValid), 576'(1));
        reset = 1'b0;
        #1;
        chk("rst_mid_status", {deskewDone, deskewError, bus.alignedValid}, 3'b000);
        chk("rst_mid_data", {bus.alignedDataK, bus.alignedData}, '0);
        #1 reset = 1'b1;
        sb.delete();
        bus.laneValid = 1'b0;
        run_vec(vt[1], "redeskew");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_deskew_ctrl.md
LANE_DESKEW_CTRL -- requirements
Module: lane_deskew_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, meaning per-lane deskew FIFO depth in lane words.
REQ-002 Parameter COM_SYM, default 8'hBC, meaning alignment marker byte, valid only with its K bit set.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  start/hold deskew; low aborts and flushes.
REQ-006 PIPEWIDTH  input  6  bits per lane per cycle; only 32 is supported.
REQ-007 LANESNUMBER  input  5  active lanes; legal values are 1, 2, 4, 8 and 16.
REQ-008 laneData  input  512  lane n word at [32n+31:32n], byte 0 in the low byte.
REQ-009 laneDataK  input  64  lane n K bits at [4n+3:4n], bit 4n for byte 0.
REQ-010 laneValid  input  1  laneData/laneDataK qualified this cycle.
REQ-011 alignedData  output  512  deskewed lane words, same packing as laneData, feeding the unstriping datapath.
REQ-012 alignedDataK  output  64  deskewed K bits.
REQ-013 alignedValid  output  1  alignedData/alignedDataK qualified, one-cycle pulse per word set.
REQ-014 deskewDone  output  1  high while in ALIGNED.
REQ-015 deskewError  output  1  sticky error flag, high while in ERROR.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_MARK, ALIGNED and ERROR.
REQ-017 A lane SHALL be active when its index is below the latched lane count; configuration SHALL be latched on IDLE->WAIT_MARK and ignored until IDLE is re-entered.
REQ-018 IDLE->WAIT_MARK SHALL occur when enable=1, PIPEWIDTH=32 and LANESNUMBER is legal; otherwise the FSM stays in IDLE.
REQ-019 A marker on lane n SHALL be byte 0 == COM_SYM with K bit 4n = 1 while laneValid=1.
REQ-020 In WAIT_MARK, a lane SHALL push its marker word and every later valid word into its FIFO; lanes with no marker yet seen push nothing.
REQ-021 A skew counter SHALL start at the first marker cycle (value 0) and increment on each later laneValid cycle while WAIT_MARK.
REQ-022 WAIT_MARK->ALIGNED SHALL occur on the cycle the last active lane's marker is pushed.
REQ-023 WAIT_MARK->ERROR SHALL occur when the skew counter reaches DEPTH with any active lane still unmarked.
REQ-024 In ALIGNED, each laneValid cycle SHALL push every active lane and pop every active lane together, so occupancy stays constant and no FIFO overflows or underflows.
REQ-025 A popped word set SHALL appear on alignedData/alignedDataK with alignedValid=1 on the next clock (registered output).
REQ-026 Inactive lanes' fields on alignedData/alignedDataK SHALL be zero at all times.
REQ-027 In ALIGNED, if a popped set has a marker on some but not all active lanes, the FSM SHALL go to ERROR and that set SHALL NOT be output.
REQ-028 enable=0 in any state SHALL force IDLE on the next clock, flush all FIFOs, clear marker flags and the skew counter, and zero all outputs.
REQ-029 Once in ERROR, the FSM SHALL stay there with deskewError=1 until enable=0.
REQ-030 alignedValid SHALL be 0 outside ALIGNED.
REQ-031 Total latency for a lane SHALL be its FIFO occupancy plus one cycle; the latest lane's latency is 1 + 1 valid cycles.

Reset
REQ-032 On reset low, the FSM SHALL enter IDLE, FIFOs SHALL be empty, counters and marker flags SHALL be zero, and all outputs SHALL be 0.
REQ-033 Reset deassertion SHALL take effect synchronously to clk; the first transition is no earlier than the first clk edge after release.

Structure
REQ-034 The shared PCIe MAC package SHALL hold the FSM state encoding, COM_SYM and the legal lane-count constants.
REQ-035 A sub-module lane_deskew_fifo (one lane, 36-bit entries, DEPTH entries, push/pop/flush) SHALL be instantiated 16 times.

Verification
REQ-036 16 lanes with zero skew and the marker on all lanes in the same cycle -> ALIGNED next clock, and after 1 valid cycle alignedData equals laneData with alignedValid=1.
REQ-037 4 lanes, with lane 2's marker 3 valid cycles after lanes 0, 1 and 3 -> ALIGNED, the first output set carries 8'hBC on all 4 lanes, and lanes 4-15 output zero.
REQ-038 8 lanes, with lane 7 unmarked 4 valid cycles after the first marker -> ERROR and deskewError=1; enable=0 -> IDLE next clock with all outputs 0.
REQ-039 In ALIGNED with 2 lanes, inject a marker on lane 0 only -> ERROR and no alignedValid for that set.
REQ-040 LANESNUMBER=3 or PIPEWIDTH=16 with enable=1 -> remains in IDLE with all outputs 0.
REQ-041 Reset asserted mid-ALIGNED -> outputs 0 immediately, and the block re-deskews correctly after enable is reapplied.
